// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
package regfile_pkg;

   localparam int AW_DEF = 4;
   localparam int DW_DEF = 32;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // Ceiling log2, never less than 1 so single-value fields still get a bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side bus and the registered write port of the arbiter.
interface regfile_wr_arbiter_if
   import regfile_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] data;
   logic [NREQ-1:0]    gnt;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [DW-1:0]      wr_data;
   logic               busy;

   modport master (
      output req, addr, data,
      input  gnt, wr_en, wr_addr, wr_data, busy
   );

   modport slave (
      input  req, addr, data,
      output gnt, wr_en, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_priority_pick
   import regfile_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;

   // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
   always_comb begin
      int s;
      s     = 0;
      dbl   = {req, req} >> ptr;
      rot   = dbl[N-1:0];
      valid = 1'b0;
      idx   = '0;
      // Walk from the far end so the nearest offset is the last to write.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            valid = 1'b1;
            idx   = PW'(s);
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between NREQ requesters with
// round-robin arbitration and a bounded burst per owner.
//
// state | meaning
// IDLE  | nobody owns the port; grant the round-robin pick from ptr
// OWN   | owner holds the port for up to MAX_BURST consecutive grants
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MAX_BURST = 4
) (
   input logic clk,
   input logic rst,
   regfile_wr_arbiter_if.slave bus
);

   localparam int PW = clog2(NREQ);
   localparam int CW = clog2(MAX_BURST + 1);

   state_t        state, nxt_state;
   logic [PW-1:0] owner, nxt_owner;
   logic [PW-1:0] ptr, nxt_ptr;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [PW-1:0] owner_inc, pick_ptr, pick_idx, gnt_idx;
   logic          pick_valid, gnt_valid, keep, accept;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   // Owner successor and the keep-the-burst decision.
   always_comb begin
      owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
      keep      = (state == OWN) && bus.req[owner] && (cnt < CW'(MAX_BURST));
      // On release the scan restarts just past the owner, so it only wins
      // back the port when nobody else is asking.
      pick_ptr  = (state == OWN) ? owner_inc : ptr;
   end

   rr_priority_pick #(.N(NREQ), .PW(PW)) u_pick (
      .req   (bus.req),
      .ptr   (pick_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // State register; reset drops any ownership in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= nxt_state;
         owner <= nxt_owner;
         ptr   <= nxt_ptr;
         cnt   <= nxt_cnt;
      end
   end

   // Next-state: continue burst, or release and re-arbitrate with no bubble.
   always_comb begin
      nxt_state = state;
      nxt_owner = owner;
      nxt_ptr   = ptr;
      nxt_cnt   = cnt;
      gnt_valid = 1'b0;
      gnt_idx   = owner;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               nxt_state = OWN;
               nxt_owner = pick_idx;
               nxt_cnt   = CW'(1);
               gnt_valid = 1'b1;
               gnt_idx   = pick_idx;
            end
         end
         OWN: begin
            if (keep) begin
               nxt_cnt   = cnt + CW'(1);
               gnt_valid = 1'b1;
               gnt_idx   = owner;
            end else begin
               nxt_ptr = owner_inc;
               if (pick_valid) begin
                  nxt_owner = pick_idx;
                  nxt_cnt   = CW'(1);
                  gnt_valid = 1'b1;
                  gnt_idx   = pick_idx;
               end else begin
                  nxt_state = IDLE;
                  nxt_cnt   = '0;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Grant output; held at zero while reset is asserted.
   always_comb begin
      bus.gnt = '0;
      accept  = gnt_valid && !rst;
      if (accept) bus.gnt[gnt_idx] = 1'b1;
   end

   // Select the granted requester's address and data.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == PW'(i)) begin
            sel_addr = bus.addr[i*AW +: AW];
            sel_data = bus.data[i*DW +: DW];
         end
      end
   end

   // Registered write port; address/data hold when nothing is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.busy    <= 1'b0;
      end else begin
         bus.wr_en <= accept;
         bus.busy  <= (nxt_state == OWN);
         if (accept) begin
            bus.wr_addr <= sel_addr;
            bus.wr_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: two instances (burst 4 and burst 2) share
// stimulus and are compared each cycle with a behavioural model.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [15:0]  addr;
   logic [127:0] data;

   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.NREQ(4), .AW(4), .DW(32)) bus4 ();
   regfile_wr_arbiter_if #(.NREQ(4), .AW(4), .DW(32)) bus2 ();

   assign bus4.req  = req;
   assign bus4.addr = addr;
   assign bus4.data = data;
   assign bus2.req  = req;
   assign bus2.addr = addr;
   assign bus2.data = data;

   regfile_wr_arbiter #(.NREQ(4), .AW(4), .DW(32), .MAX_BURST(4)) dut4 (
      .clk (clk), .rst (rst), .bus (bus4));
   regfile_wr_arbiter #(.NREQ(4), .AW(4), .DW(32), .MAX_BURST(2)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2));

   int checks = 0;
   int errors = 0;

   // Model: who owns the port, how many grants it has had, where the scan starts.
   int          mb [2] = '{4, 2};
   bit          m_own [2];
   int          m_owner [2];
   int          m_ptr [2];
   int          m_cnt [2];
   logic        m_wr_en [2];
   logic [3:0]  m_wr_addr [2];
   logic [31:0] m_wr_data [2];
   logic        m_busy [2];
   logic [3:0]  gnt_seen [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] onehot(input int w);
      return (w < 0) ? 4'b0000 : 4'(1 << w);
   endfunction

   function automatic int scan_from(input int start, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   function automatic int model_winner(input int d);
      if (rst) return -1;
      if (!m_own[d]) return scan_from(m_ptr[d], req);
      if (req[m_owner[d]] && m_cnt[d] < mb[d]) return m_owner[d];
      return scan_from((m_owner[d] + 1) % 4, req);
   endfunction

   task automatic model_reset(input int d);
      m_own[d] = 1'b0; m_owner[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      m_wr_en[d] = 1'b0; m_wr_addr[d] = '0; m_wr_data[d] = '0; m_busy[d] = 1'b0;
   endtask

   task automatic model_step(input int d, input int w);
      if (rst) begin
         model_reset(d);
         return;
      end
      if (m_own[d] && req[m_owner[d]] && m_cnt[d] < mb[d]) begin
         m_cnt[d]++;
      end else begin
         if (m_own[d]) m_ptr[d] = (m_owner[d] + 1) % 4;
         if (w >= 0) begin
            m_own[d] = 1'b1; m_owner[d] = w; m_cnt[d] = 1;
         end else begin
            m_own[d] = 1'b0; m_cnt[d] = 0;
         end
      end
      m_wr_en[d] = (w >= 0);
      if (w >= 0) begin
         m_wr_addr[d] = addr[w*4 +: 4];
         m_wr_data[d] = data[w*32 +: 32];
      end
      m_busy[d] = m_own[d];
   endtask

   // One clock: check grant mid-cycle, advance model, check registered outputs.
   task automatic cycle();
      int w [2];
      #2;
      gnt_seen[0] = bus4.gnt;
      gnt_seen[1] = bus2.gnt;
      for (int d = 0; d < 2; d++) begin
         w[d] = model_winner(d);
         chk($sformatf("gnt_b%0d", mb[d]), 32'(gnt_seen[d]), 32'(onehot(w[d])));
         model_step(d, w[d]);
      end
      @(posedge clk);
      #1;
      chk("wr_en_b4",   32'(bus4.wr_en),   32'(m_wr_en[0]));
      chk("wr_addr_b4", 32'(bus4.wr_addr), 32'(m_wr_addr[0]));
      chk("wr_data_b4", bus4.wr_data,      m_wr_data[0]);
      chk("busy_b4",    32'(bus4.busy),    32'(m_busy[0]));
      chk("wr_en_b2",   32'(bus2.wr_en),   32'(m_wr_en[1]));
      chk("wr_addr_b2", 32'(bus2.wr_addr), 32'(m_wr_addr[1]));
      chk("wr_data_b2", bus2.wr_data,      m_wr_data[1]);
      chk("busy_b2",    32'(bus2.busy),    32'(m_busy[1]));
   endtask

   int seq_rot [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
   int seq_early [3] = '{1, 1, 3};

   initial begin
      model_reset(0);
      model_reset(1);
      rst = 1'b1; req = '0; addr = '0; data = '0;

      // Reset then idle.
      cycle();
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("idle_gnt", 32'(gnt_seen[0]), 32'h0);
         chk("idle_wr_en", 32'(bus4.wr_en), 32'h0);
         chk("idle_wr_addr", 32'(bus4.wr_addr), 32'h0);
         chk("idle_wr_data", bus4.wr_data, 32'h0);
         chk("idle_busy", 32'(bus4.busy), 32'h0);
      end

      // Single write from requester 2.
      req = 4'b0100; addr[8 +: 4] = 4'hA; data[64 +: 32] = 32'hDEADBEEF;
      cycle();
      chk("single_gnt", 32'(gnt_seen[0]), 32'h4);
      chk("single_wr_en", 32'(bus4.wr_en), 32'h1);
      chk("single_wr_addr", 32'(bus4.wr_addr), 32'hA);
      chk("single_wr_data", bus4.wr_data, 32'hDEADBEEF);
      req = 4'b0000;
      cycle();
      chk("single_after_wr_en", 32'(bus4.wr_en), 32'h0);
      cycle();

      // Burst cap: sole requester 0 for 6 cycles, no bubble.
      for (int k = 0; k < 6; k++) begin
         req = 4'b0001; addr[3:0] = 4'(k); data[31:0] = 32'(100 + k);
         cycle();
         chk("burst_gnt", 32'(gnt_seen[0]), 32'h1);
         chk("burst_wr_en", 32'(bus4.wr_en), 32'h1);
         chk("burst_wr_addr", 32'(bus4.wr_addr), 32'(k));
      end
      req = 4'b0000;
      cycle();

      // Fair rotation on the burst-2 instance.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req = 4'b1111; addr = 16'hDCBA;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("rot_gnt", 32'(gnt_seen[1]), 32'(onehot(seq_rot[k])));
         chk("rot_wr_addr", 32'(bus2.wr_addr), 32'(4'hA + 4'(seq_rot[k])));
      end

      // Early release on the burst-4 instance.
      rst = 1'b1; req = 4'b0000;
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req = (k < 2) ? 4'b1010 : 4'b1000;
         cycle();
         chk("early_gnt", 32'(gnt_seen[0]), 32'(onehot(seq_early[k])));
         chk("early_busy", 32'(bus4.busy), 32'h1);
      end
      req = 4'b0000;
      cycle();

      // Reset in the middle of requester 2's burst.
      rst = 1'b1;
      cycle();
      rst = 1'b0; req = 4'b0100;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      chk("rstmid_gnt", 32'(gnt_seen[0]), 32'h0);
      chk("rstmid_wr_en", 32'(bus4.wr_en), 32'h0);
      chk("rstmid_busy", 32'(bus4.busy), 32'h0);
      rst = 1'b0; req = 4'b0110;
      cycle();
      chk("rstmid_regrant", 32'(gnt_seen[0]), 32'h2);

      // Random traffic with occasional reset.
      for (int k = 0; k < 400; k++) begin
         rst  = ($urandom_range(0, 39) == 0);
         req  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) & 4'b0101
                                            : 4'($urandom_range(0, 15));
         addr = 16'($urandom);
         data = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
